// File: rtl/seq_ram_pkg.sv
// Shared types and helpers for the sequential RAM controller.
// Holds the controller state encoding, the read-during-write mode constants and the byte-merge function.
package seq_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/seq_ram_pipe.sv
// Return-path delay line carrying {valid, data}.
// Each stage loads data only alongside a valid, so the tail holds the last returned word between returns.
module seq_ram_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-2:0] data_p [DEPTH];

  // stage 0 captures the request-cycle return word; later stages are plain register hops
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
    end else begin
      vld_p[0] <= d[WIDTH-1];
      if (d[WIDTH-1]) data_p[0] <= d[WIDTH-2:0];
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign q = {vld_p[DEPTH-1], data_p[DEPTH-1]};

endmodule

// File: rtl/seq_ram_ctrl.sv
// Single-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write return and an optional zero-fill sweep after reset.
module seq_ram_ctrl
  import seq_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int INIT_ZERO    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rvalid
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam ram_state_t RST_STATE = (INIT_ZERO != 0) ? INIT : RUN;

  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("seq_ram_ctrl: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
    $error("seq_ram_ctrl: DATA_WIDTH must be a multiple of 8 and fit the merge helper");
  end

  ram_state_t            state;
  ram_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_last;
  logic                  init_we;
  logic                  accept;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] ret_data;
  logic [DATA_WIDTH:0]   pipe_q;

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_last) state_nxt = RUN;
  end

  always_comb begin
    ready   = (state == RUN);
    init_we = (state == INIT) && !rst;
  end

  assign init_last = &init_addr;

  always_ff @(posedge clk) begin
    if (rst)                 init_addr <= '0;
    else if (state == INIT)  init_addr <= init_addr + ADDR_WIDTH'(1);
  end

  // A request landing on the reset edge is dropped so nothing is written or returned.
  assign accept    = en && ready && !rst;
  assign wr_accept = accept && wen;

  assign rd_word = mem[addr];
  assign merged  = DATA_WIDTH'(be_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(din), MAX_BE_W'(be)));

  always_comb begin
    ret_data = rd_word;
    if (wen && RDW_MODE == RDW_WRITE_FIRST) ret_data = merged;
  end

  // Memory contents survive reset; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (init_we)        mem[init_addr] <= '0;
    else if (wr_accept) mem[addr]      <= merged;
  end

  seq_ram_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (DATA_WIDTH + 1)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({accept, ret_data}),
    .q   (pipe_q)
  );

  assign rvalid = pipe_q[DATA_WIDTH];
  assign dout   = pipe_q[DATA_WIDTH-1:0];

endmodule
